// File: rtl/acq_window_sequencer.sv
// acq_window_sequencer: sequences one acquisition window of the correlator bank.
// Software start -> CLEAR pulse -> ACQ (gated ADC pushes, hit accumulation) ->
// SCAN (hand each hit index to the logger over valid/ready) -> DONE.
// Optional: define FIRST_HIT_EN to build the FIRSTHIT capture register.
module acq_window_sequencer #(
    parameter int unsigned NCORR = 32,
    parameter int unsigned CNT_W = 32,
    parameter logic [31:0] BASE  = 32'hfe00_0110,
    localparam int unsigned IDX_W = $clog2(NCORR)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [31:0]      i_addr,
    input  logic [31:0]      i_wdata,
    input  logic             i_write,
    input  logic             i_read,
    output logic [31:0]      o_rdata,
    input  logic             i_push_adc,
    input  logic [NCORR-1:0] i_cseen,
    output logic             o_adc_push_out,
    output logic             o_corr_clr,
    output logic             o_hit_valid,
    output logic [IDX_W-1:0] o_hit_idx,
    input  logic             i_hit_ready,
    output logic             o_busy,
    output logic             o_irq
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StAcq   = 3'd2,
        StScan  = 3'd3,
        StDone  = 3'd4
    } state_e;

    state_e           r_state;
    logic             r_continuous;
    logic             r_irq_en;
    logic [CNT_W-1:0] r_window;
    logic [CNT_W-1:0] r_win_shadow;
    logic [CNT_W-1:0] r_sample_cnt;
    logic             r_done;
    logic             r_aborted;
    logic [NCORR-1:0] r_hits;
    logic [IDX_W-1:0] r_scan_idx;

    logic        w_wr_ctrl;
    logic        w_wr_window;
    logic        w_wr_status;
    logic        w_start;
    logic        w_abort;
    logic        w_abort_act;
    logic        w_latch;
    logic        w_last_push;
    logic        w_cur_hit;
    logic        w_scan_adv;
    logic        w_scan_end;
    logic [31:0] w_first_hit;

    assign w_wr_ctrl   = i_write && (i_addr == BASE);
    assign w_wr_window = i_write && (i_addr == BASE + 32'd4);
    assign w_wr_status = i_write && (i_addr == BASE + 32'd8);
    assign w_start     = w_wr_ctrl && i_wdata[0];
    assign w_abort     = w_wr_ctrl && i_wdata[1];
    assign w_abort_act = w_abort && (r_state != StIdle);

    // A window latch happens on a start from idle or on a continuous restart from done;
    // abort in the same write always wins, and a zero window never starts.
    assign w_latch = !w_abort && (r_window != '0) &&
                     (((r_state == StIdle) && w_start) || ((r_state == StDone) && r_continuous));

    // win_shadow is never 0 inside a window, so the counter never wraps.
    assign w_last_push = i_push_adc && (r_sample_cnt == r_win_shadow - 1'b1);
    assign w_cur_hit   = r_hits[r_scan_idx];
    assign w_scan_adv  = !w_cur_hit || i_hit_ready;
    assign w_scan_end  = (r_scan_idx == IDX_W'(NCORR - 1));

    // Control registers and window sequencing FSM
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state      <= StIdle;
            r_continuous <= 1'b0;
            r_irq_en     <= 1'b0;
            r_window     <= '0;
            r_win_shadow <= '0;
            r_sample_cnt <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_hits       <= '0;
            r_scan_idx   <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_continuous <= i_wdata[2];
                r_irq_en     <= i_wdata[3];
            end
            if (w_wr_window) begin
                r_window <= i_wdata[CNT_W-1:0];
            end
            // Sticky clears come first so a same-cycle set below overrides them.
            if (w_wr_status && i_wdata[8]) begin
                r_done <= 1'b0;
            end
            if (w_wr_status && i_wdata[9]) begin
                r_aborted <= 1'b0;
            end

            if (w_abort_act) begin
                r_state   <= StIdle;
                r_aborted <= 1'b1;
            end else begin
                if (w_latch) begin
                    r_win_shadow <= r_window;
                    r_sample_cnt <= '0;
                    r_hits       <= '0;
                    r_scan_idx   <= '0;
                end
                case (r_state)
                    StIdle: begin
                        if (w_latch) begin
                            r_state <= StClear;
                        end
                    end
                    StClear: r_state <= StAcq;
                    StAcq: begin
                        r_hits <= r_hits | i_cseen;
                        if (i_push_adc) begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                            if (w_last_push) begin
                                r_state <= StScan;
                            end
                        end
                    end
                    StScan: begin
                        if (w_scan_adv) begin
                            if (w_scan_end) begin
                                r_state <= StDone;
                            end else begin
                                r_scan_idx <= r_scan_idx + 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        r_done  <= 1'b1;
                        r_state <= w_latch ? StClear : StIdle;
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

`ifdef FIRST_HIT_EN
    logic [31:0] r_first_hit;
    logic [31:0] w_cnt32;
    logic        w_unused_cnt_msb;

    assign w_cnt32          = 32'(r_sample_cnt);
    assign w_unused_cnt_msb = w_cnt32[31];
    assign w_first_hit      = r_first_hit;

    // Capture the sample count at the first ACQ cycle with any correlator seen; bit31 = valid
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_first_hit <= '0;
        end else if (w_latch) begin
            r_first_hit <= '0;
        end else if ((r_state == StAcq) && !w_abort_act && !r_first_hit[31] && (|i_cseen)) begin
            r_first_hit <= {1'b1, w_cnt32[30:0]};
        end
    end
`else
    assign w_first_hit = '0;
`endif

    assign o_adc_push_out = (r_state == StAcq) && i_push_adc;
    assign o_corr_clr     = (r_state == StClear);
    assign o_hit_valid    = (r_state == StScan) && w_cur_hit;
    assign o_hit_idx      = o_hit_valid ? r_scan_idx : '0;
    assign o_busy         = (r_state != StIdle);
    assign o_irq          = r_done && r_irq_en;

    // Combinational register read mux; zero when not reading or unmapped
    always_comb begin
        o_rdata = '0;
        if (i_read) begin
            case (i_addr)
                BASE:          o_rdata = {28'd0, r_irq_en, r_continuous, 2'b00};
                BASE + 32'd4:  o_rdata = 32'(r_window);
                BASE + 32'd8:  o_rdata = {22'd0, r_aborted, r_done, 5'd0, r_state};
                BASE + 32'hC:  o_rdata = 32'(r_hits);
                BASE + 32'h10: o_rdata = w_first_hit;
                default:       o_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_acq_window_sequencer.sv
// Self-checking bench for acq_window_sequencer: directed scenarios with literal
// expectations plus a randomized run, all compared every cycle against a
// behavioural model of the window sequence.
module tb_acq_window_sequencer;

    localparam logic [31:0] BASE  = 32'hfe00_0110;
    localparam int          NCORR = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic        read;
    logic [31:0] rdata;
    logic        push;
    logic [31:0] cseen;
    logic        adc_out;
    logic        corr_clr;
    logic        hit_valid;
    logic [4:0]  hit_idx;
    logic        hit_ready;
    logic        busy;
    logic        irq;

    acq_window_sequencer dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .i_write        (write),
        .i_read         (read),
        .o_rdata        (rdata),
        .i_push_adc     (push),
        .i_cseen        (cseen),
        .o_adc_push_out (adc_out),
        .o_corr_clr     (corr_clr),
        .o_hit_valid    (hit_valid),
        .o_hit_idx      (hit_idx),
        .i_hit_ready    (hit_ready),
        .o_busy         (busy),
        .o_irq          (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase 0 idle, 1 clear, 2 acquire, 3 scan, 4 done.
    int          m_state;
    logic [31:0] m_window, m_shadow, m_cnt, m_hits, m_fh;
    bit          m_cont, m_irqen, m_done, m_abt;
    int          m_scanq[$];   // correlator indices still to visit in the scan

    // Observations of DUT behaviour for directed checks.
    int obs_push;
    int obs_clr[$];    // push count at each clear pulse
    int obs_hits[$];   // hit indices accepted by the logger

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_window = 0; m_shadow = 0; m_cnt = 0; m_hits = 0; m_fh = 0;
        m_cont = 0; m_irqen = 0; m_done = 0; m_abt = 0;
        m_scanq.delete();
    endtask

    task automatic begin_window(input logic [31:0] w);
        m_shadow = w; m_hits = 0; m_cnt = 0; m_fh = 0; m_state = 1;
    endtask

    function automatic logic [31:0] m_rdata();
        if (!read) return 32'd0;
        case (addr)
            BASE:          return {28'd0, m_irqen, m_cont, 2'b00};
            BASE + 32'd4:  return m_window;
            BASE + 32'd8:  return {22'd0, m_abt, m_done, 5'd0, 3'(m_state)};
            BASE + 32'hC:  return m_hits;
            BASE + 32'h10: return m_fh;
            default:       return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit          wc, ww, ws, st, ab, cont_old;
        logic [31:0] win_old;
        wc = write && (addr == BASE);
        ww = write && (addr == BASE + 32'd4);
        ws = write && (addr == BASE + 32'd8);
        st = wc && wdata[0];
        ab = wc && wdata[1];
        win_old  = m_window;
        cont_old = m_cont;
        if (wc) begin m_cont = wdata[2]; m_irqen = wdata[3]; end
        if (ww) m_window = wdata;
        if (ws && wdata[8]) m_done = 0;
        if (ws && wdata[9]) m_abt = 0;
        if (ab && m_state != 0) begin
            m_state = 0;
            m_abt   = 1;
        end else begin
            case (m_state)
                0: if (st && !ab && win_old != 0) begin_window(win_old);
                1: m_state = 2;
                2: begin
`ifdef FIRST_HIT_EN
                    if (!m_fh[31] && cseen != 0) m_fh = 32'h8000_0000 | m_cnt;
`endif
                    m_hits |= cseen;
                    if (push) begin
                        m_cnt++;
                        if (m_cnt == m_shadow) begin
                            m_state = 3;
                            m_scanq.delete();
                            for (int i = 0; i < NCORR; i++) m_scanq.push_back(i);
                        end
                    end
                end
                3: if (!m_hits[m_scanq[0]] || hit_ready) begin
                    void'(m_scanq.pop_front());
                    if (m_scanq.size() == 0) m_state = 4;
                end
                4: begin
                    m_done = 1;
                    if (cont_old && win_old != 0) begin_window(win_old);
                    else m_state = 0;
                end
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: compare every output against the model, record observations, advance.
    task automatic cyc();
        bit exp_valid;
        int exp_idx;
        if (!rst) model_reset();
        #1;
        exp_valid = (m_state == 3) && m_hits[m_scanq[0]];
        exp_idx   = exp_valid ? m_scanq[0] : 0;
        chk("adc_push_out", adc_out, (m_state == 2) && push);
        chk("corr_clr", corr_clr, m_state == 1);
        chk("hit_valid", hit_valid, exp_valid);
        chk("hit_idx", hit_idx, exp_idx);
        chk("busy", busy, m_state != 0);
        chk("irq", irq, m_done && m_irqen);
        chk("rdata", rdata, m_rdata());
        if (adc_out) obs_push++;
        if (corr_clr) obs_clr.push_back(obs_push);
        if (hit_valid && hit_ready) obs_hits.push_back(int'(hit_idx));
        @(posedge clk);
        if (!rst) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; write = 1'b1;
        cyc();
        write = 1'b0; addr = '0; wdata = '0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a; read = 1'b1;
        #1;
        chk(name, rdata, exp);
        cyc();
        read = 1'b0; addr = '0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin cyc(); n++; end
        if (busy) chk({name, " idle timeout"}, busy, 0);
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n;
        n = 0;
        while (!hit_valid && n < limit) begin cyc(); n++; end
        if (!hit_valid) chk({name, " hit_valid timeout"}, hit_valid, 1);
    endtask

    task automatic clear_obs();
        obs_push = 0; obs_clr.delete(); obs_hits.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[3];
        int n;
        bit wrote;
        bit did_reset;
        int r;

        rst = 1'b0; addr = '0; wdata = '0; write = 1'b0; read = 1'b0;
        push = 1'b0; cseen = '0; hit_ready = 1'b0;
        model_reset();
        clear_obs();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset state and zero-window start
        chk("rst corr_clr", corr_clr, 0);
        chk("rst hit_valid", hit_valid, 0);
        chk("rst irq", irq, 0);
        chk("rst busy", busy, 0);
        rd("rst CTRL", BASE, 0);
        rd("rst WINDOW", BASE + 4, 0);
        rd("rst STATUS", BASE + 8, 0);
        rd("rst HITS", BASE + 32'hC, 0);
        rd("rst FIRSTHIT", BASE + 32'h10, 0);
        wr(BASE, 32'h1);
        chk("start w0 busy", busy, 0);
        rd("start w0 STATUS", BASE + 8, 0);

        // Window of 4 with a single hit on correlator 5
        wr(BASE + 4, 4);
        hit_ready = 1'b1;
        clear_obs();
        wr(BASE, 32'h9);
        n = 0;
        while (busy && n < 200) begin
            push  = n[0];
            cseen = (push && obs_push == 1) ? 32'h20 : 32'h0;
            cyc();
            n++;
        end
        push = 1'b0; cseen = '0;
        chk("t2 idle", busy, 0);
        chk("t2 clr count", obs_clr.size(), 1);
        chk("t2 push count", obs_push, 4);
        chk("t2 hit count", obs_hits.size(), 1);
        if (obs_hits.size() > 0) chk("t2 hit idx", obs_hits[0], 5);
        chk("t2 irq", irq, 1);
        rd("t2 STATUS", BASE + 8, 32'h100);
        rd("t2 HITS", BASE + 32'hC, 32'h20);
        wr(BASE + 8, 32'h100);
        chk("t2 irq cleared", irq, 0);

        // Hits 0,7,31 with logger back-pressure
        wr(BASE + 8, 32'h300);
        wr(BASE + 4, 2);
        cseen = 32'h8000_0081; push = 1'b1; hit_ready = 1'b0;
        clear_obs();
        wr(BASE, 32'h1);
        exp_order[0] = 0; exp_order[1] = 7; exp_order[2] = 31;
        for (int k = 0; k < 3; k++) begin
            wait_valid("t3", 100);
            chk("t3 idx", hit_idx, exp_order[k]);
            for (int j = 0; j < 3; j++) begin
                cyc();
                chk("t3 hold valid", hit_valid, 1);
                chk("t3 hold idx", hit_idx, exp_order[k]);
            end
            hit_ready = 1'b1;
            cyc();
            hit_ready = 1'b0;
        end
        cseen = '0;
        wait_idle("t3", 100);
        chk("t3 hit count", obs_hits.size(), 3);
        rd("t3 STATUS", BASE + 8, 32'h100);

        // Continuous mode with a window rewrite during the first window
        wr(BASE + 8, 32'h300);
        push = 1'b1; hit_ready = 1'b1; cseen = '0;
        wr(BASE + 4, 3);
        clear_obs();
        wr(BASE, 32'h5);
        wrote = 0;
        n = 0;
        while (obs_clr.size() < 3 && n < 400) begin
            if (obs_clr.size() >= 1 && !wrote) begin
                wr(BASE + 4, 5);
                wrote = 1;
            end else begin
                cyc();
            end
            n++;
        end
        chk("t4 clr count", obs_clr.size(), 3);
        if (obs_clr.size() >= 3) begin
            chk("t4 window1 pushes", obs_clr[1] - obs_clr[0], 3);
            chk("t4 window2 pushes", obs_clr[2] - obs_clr[1], 5);
        end
        wr(BASE, 32'h2);
        chk("t4 abort busy", busy, 0);
        rd("t4 STATUS", BASE + 8, 32'h300);

        // Abort during SCAN with a pending hit, then start+abort together
        wr(BASE + 8, 32'h300);
        wr(BASE + 4, 1);
        cseen = 32'h200; push = 1'b1; hit_ready = 1'b0;
        wr(BASE, 32'h1);
        wait_valid("t5", 100);
        chk("t5 idx", hit_idx, 9);
        cseen = '0;
        wr(BASE, 32'h2);
        chk("t5 hit_valid drop", hit_valid, 0);
        chk("t5 busy", busy, 0);
        rd("t5 STATUS", BASE + 8, 32'h200);
        rd("t5 HITS kept", BASE + 32'hC, 32'h200);
        wr(BASE + 8, 32'h200);
        wr(BASE, 32'h3);
        chk("t5 start+abort busy", busy, 0);
        rd("t5 STATUS2", BASE + 8, 32'h0);

        // First-hit capture
        wr(BASE + 4, 10);
        push = 1'b1; hit_ready = 1'b1;
        clear_obs();
        wr(BASE, 32'h1);
        n = 0;
        while (busy && n < 200) begin
            cseen = (obs_push >= 6) ? 32'h8 : 32'h0;
            cyc();
            n++;
        end
        cseen = '0;
        chk("t6 idle", busy, 0);
`ifdef FIRST_HIT_EN
        rd("t6 FIRSTHIT", BASE + 32'h10, 32'h8000_0006);
`else
        rd("t6 FIRSTHIT", BASE + 32'h10, 32'h0);
`endif
        wr(BASE + 4, 32'hffff_ffff);
        rd("t6 WINDOW max", BASE + 4, 32'hffff_ffff);
        wr(BASE + 8, 32'h300);

        // Randomized traffic, with one asynchronous reset in the middle of a window
        did_reset = 0;
        for (int it = 0; it < 4000; it++) begin
            push      = 1'($urandom_range(0, 1));
            hit_ready = ($urandom_range(0, 3) != 0);
            cseen     = ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
            write = 1'b0; read = 1'b0; addr = '0; wdata = '0;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                write = 1'b1; addr = BASE;
                wdata = {28'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0)};
            end else if (r < 8) begin
                write = 1'b1; addr = BASE + 4; wdata = $urandom_range(0, 6);
            end else if (r < 10) begin
                write = 1'b1; addr = BASE + 8; wdata = $urandom & 32'h300;
            end else if (r < 30) begin
                read = 1'b1; addr = BASE + 32'(4 * $urandom_range(0, 5));
            end
            if (!did_reset && it >= 2000 && busy) begin
                did_reset = 1;
                rst = 1'b0;
                #1;
                chk("async reset busy", busy, 0);
                chk("async reset hit_valid", hit_valid, 0);
                cyc();
                rst = 1'b1;
                rd("async reset STATUS", BASE + 8, 0);
            end else begin
                cyc();
            end
        end
        write = 1'b0; read = 1'b0; push = 1'b0; cseen = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/acq_window_sequencer.md
Name: acq_window_sequencer

Overview:
- Sequences one acquisition window of the spread-spectrum correlator bank.
- On a software start it pulses clear to the correlators, then gates ADC pushes to them for a programmed number of samples.
- It accumulates the correlators' seen flags for the window, then scans the hit set and hands each hit index to the result logger over a valid/ready handshake.
- Lives on the fe00_01xx control bus next to the global run/sample-count registers.

Parameters:
- NCORR, 32, number of correlators / width of cseen and hit vectors
- CNT_W, 32, width of window length and sample counter
- BASE, 32'hfe00_0110, byte address of the CTRL register; other registers at BASE+4, +8, +C, +10

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- addr  in  32  bus byte address
- wdata  in  32  bus write data
- write  in  1  bus write strobe, single cycle
- read  in  1  bus read strobe
- rdata  out  32  combinational read data
- push_adc  in  1  ADC sample strobe
- cseen  in  NCORR  per-correlator correlation-seen flags
- adc_push_out  out  1  gated push to correlators
- corr_clr  out  1  one-cycle correlator clear pulse
- hit_valid  out  1  hit index available
- hit_idx  out  5  correlator index of the hit (log2 NCORR)
- hit_ready  in  1  logger accepts the hit
- busy  out  1  state != IDLE
- irq  out  1  level interrupt = done_sticky & irq_en

Behaviour:
- Register map:
  - CTRL @BASE: bit0 start (write-1 pulse, reads 0), bit1 abort (write-1 pulse, reads 0), bit2 continuous, bit3 irq_en.
  - WINDOW @+4: R/W, samples per window.
  - STATUS @+8: [2:0] state, bit8 done_sticky, bit9 aborted_sticky. Write-1-to-clear on bits 8–9.
  - HITS @+C: RO, accumulated hit vector.
  - FIRSTHIT @+10: see optional feature.
  - Unmapped reads return 0. rdata is 0 when read=0.
- Reset values: all registers, counters, hit vector and outputs 0; state IDLE.
- State encoding: IDLE=0, CLEAR=1, ACQ=2, SCAN=3, DONE=4.
- IDLE:
  - A start write with WINDOW!=0 goes to CLEAR. Start with WINDOW==0 is ignored.
  - In the same transition, latch win_shadow<=WINDOW, zero HITS and sample_cnt, zero scan index.
- CLEAR: corr_clr=1 for exactly this cycle, then go to ACQ.
- ACQ:
  - adc_push_out = push_adc (combinational, zero latency). adc_push_out is 0 in all other states.
  - Every cycle, HITS |= cseen.
  - On each push, sample_cnt+1.
  - A push with sample_cnt==win_shadow-1 goes to SCAN next cycle; the cseen of that cycle is still ORed in.
- SCAN:
  - Index i runs 0..NCORR-1.
  - If HITS[i]==0, advance in 1 cycle.
  - If HITS[i]==1, assert hit_valid with hit_idx=i and hold both stable until hit_ready; advance on the cycle valid&ready is high.
  - After i=NCORR-1 is consumed or skipped, go to DONE.
  - An all-zero HITS spends exactly NCORR cycles in SCAN.
- DONE: one cycle; set done_sticky. Next state is CLEAR if continuous=1 (relatch WINDOW), else IDLE.
- Abort:
  - From any non-IDLE state, go to IDLE next cycle.
  - hit_valid drops immediately on that edge; set aborted_sticky.
  - No done; HITS retained.
- Start while busy is ignored.
- WINDOW writes while busy update the register only; they take effect at the next latch.
- Simultaneous start+abort in one write: abort wins.
- Write-1-to-clear of done on the same cycle DONE sets it: the set wins.
- Reset asserted mid-window: immediate return to reset values; a pending hit is lost.
- sample_cnt is CNT_W bits; win_shadow=2^CNT_W-1 is legal, and the counter never wraps inside a window.

Optional Feature:
- Macro FIRST_HIT_EN.
- When defined:
  - FIRSTHIT holds the sample_cnt value on the first ACQ cycle where |cseen is 1, with bit31 set as a valid flag.
  - Cleared at each window latch.
  - Captured once per window.
- When undefined: FIRSTHIT reads 0 and no capture logic is built.

Test Plan:
- Reset, then read all registers → all 0; corr_clr/hit_valid/irq=0; write start with WINDOW=0 → stays IDLE, busy=0.
- WINDOW=4, irq_en=1, start; cseen bit5 high during 2nd push, hit_ready=1 → corr_clr one cycle, exactly 4 adc_push_out, single hit_idx=5, done_sticky=1, irq=1; write-1-to-clear STATUS bit8 → irq=0.
- Hits on bits 0,7,31 with hit_ready low for 3 cycles at each → hit_valid/hit_idx held stable; indices delivered in order 0,7,31; SCAN exits to DONE.
- continuous=1, WINDOW=3, rewrite WINDOW=5 mid-ACQ → first window 3 pushes, second window 5 pushes, corr_clr before each window.
- Abort during SCAN with hit_valid=1 → IDLE next cycle, hit_valid=0, aborted_sticky=1, done_sticky=0; start+abort in same write → stays IDLE.
- FIRST_HIT_EN: WINDOW=10, cseen[3] rises when sample_cnt=6 → FIRSTHIT=32'h8000_0006; without the macro, FIRSTHIT reads 0.
